// File: rtl/interrupt_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interrupt_responder
// Brief    : Takes interrupt requests, saves EPC/cause, redirects fetch to the
//            service routine, restores PC on return and tail-chains requests.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_responder #(
    parameter logic [31:0] SERVICE_PC = 32'd76,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irq_req,
    input  logic [2:0]       irq_cause,
    input  logic [31:0]      cur_pc,
    input  logic             eret,
    output logic             irq_ack,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             in_service,
    output logic [31:0]      epc,
    output logic [2:0]       cause,
    output logic [CNT_W-1:0] svc_count
);

    typedef enum logic [1:0] {
        c_idle    = 2'd0,
        c_enter   = 2'd1,
        c_service = 2'd2,
        c_exit    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_epc;
    logic [2:0]       r_cause;
    logic [2:0]       r_pending;
    logic [CNT_W-1:0] r_count;

    logic             w_valid;
    logic [2:0]       w_new_cause;
    logic [2:0]       w_pend_merged;
    logic             w_chain;
    logic [CNT_W-1:0] w_count_inc;

    // A request carrying cause 0 is treated as no request at all.
    assign w_valid       = irq_req && (irq_cause != 3'd0);
    assign w_new_cause   = w_valid ? irq_cause : 3'd0;
    assign w_pend_merged = r_pending | w_new_cause;
    assign w_chain       = (w_pend_merged != 3'd0);
    assign w_count_inc   = (r_count == c_cnt_max) ? r_count : (r_count + c_cnt_one);

    always_comb begin
        w_state_next = r_state;
        irq_ack      = 1'b0;
        pc_redirect  = 1'b0;
        flush        = 1'b0;
        redirect_pc  = 32'd0;
        in_service   = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_valid) w_state_next = c_enter;
            end
            c_enter: begin
                irq_ack      = 1'b1;
                pc_redirect  = 1'b1;
                flush        = 1'b1;
                redirect_pc  = SERVICE_PC;
                in_service   = 1'b1;
                w_state_next = c_service;
            end
            c_service: begin
                in_service = 1'b1;
                if (eret) w_state_next = c_exit;
            end
            c_exit: begin
                pc_redirect = 1'b1;
                flush       = 1'b1;
                in_service  = 1'b1;
                // Anything pending (including a request arriving right now)
                // re-enters the handler without touching the saved EPC.
                if (w_chain) begin
                    irq_ack      = 1'b1;
                    redirect_pc  = SERVICE_PC;
                    w_state_next = c_service;
                end else begin
                    redirect_pc  = r_epc;
                    w_state_next = c_idle;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_epc     <= 32'd0;
            r_cause   <= 3'd0;
            r_pending <= 3'd0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_idle: begin
                    if (w_valid) begin
                        r_epc   <= cur_pc;
                        r_cause <= irq_cause;
                        r_count <= w_count_inc;
                    end
                end
                c_enter, c_service: begin
                    r_pending <= w_pend_merged;
                end
                c_exit: begin
                    if (w_chain) begin
                        r_cause   <= w_pend_merged;
                        r_pending <= 3'd0;
                        r_count   <= w_count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign epc       = r_epc;
    assign cause     = r_cause;
    assign svc_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_responder
// Brief    : Directed and random stimulus for interrupt_responder, checked
//            cycle by cycle against a service-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_responder;

    localparam int          CNT_W  = 2;
    localparam int          CNT_MX = (1 << CNT_W) - 1;
    localparam logic [31:0] SVC_PC = 32'd76;

    logic             clk = 1'b0;
    logic             rst;
    logic             irq_req;
    logic [2:0]       irq_cause;
    logic [31:0]      cur_pc;
    logic             eret;
    logic             irq_ack;
    logic             pc_redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             in_service;
    logic [31:0]      epc;
    logic [2:0]       cause;
    logic [CNT_W-1:0] svc_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an active service episode with one-shot entry/exit
    // redirects owed in the current cycle.
    bit          m_active;
    bit          m_entry_due;
    bit          m_exit_due;
    logic [31:0] m_epc;
    logic [2:0]  m_cause;
    logic [2:0]  m_pend;
    int          m_count;

    interrupt_responder #(
        .SERVICE_PC (SVC_PC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_req     (irq_req),
        .irq_cause   (irq_cause),
        .cur_pc      (cur_pc),
        .eret        (eret),
        .irq_ack     (irq_ack),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .in_service  (in_service),
        .epc         (epc),
        .cause       (cause),
        .svc_count   (svc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] new_cause();
        return (irq_req && irq_cause != 3'd0) ? irq_cause : 3'd0;
    endfunction

    task automatic check_outputs();
        logic [2:0]  merged;
        logic        e_ack;
        logic        e_redir;
        logic [31:0] e_rpc;
        merged  = m_pend | new_cause();
        e_redir = m_entry_due || m_exit_due;
        e_ack   = m_entry_due || (m_exit_due && merged != 3'd0);
        if (m_entry_due)     e_rpc = SVC_PC;
        else if (m_exit_due) e_rpc = (merged != 3'd0) ? SVC_PC : m_epc;
        else                 e_rpc = 32'd0;
        chk("irq_ack",     {31'd0, irq_ack},     {31'd0, e_ack});
        chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, e_redir});
        chk("flush",       {31'd0, flush},       {31'd0, e_redir});
        chk("redirect_pc", redirect_pc,          e_rpc);
        chk("in_service",  {31'd0, in_service},  {31'd0, m_active});
        chk("epc",         epc,                  m_epc);
        chk("cause",       {29'd0, cause},       {29'd0, m_cause});
        chk("svc_count",   32'(svc_count),       32'(m_count));
    endtask

    task automatic model_edge();
        logic [2:0] merged;
        merged = m_pend | new_cause();
        if (rst) begin
            m_active = 0; m_entry_due = 0; m_exit_due = 0;
            m_epc = 32'd0; m_cause = 3'd0; m_pend = 3'd0; m_count = 0;
        end else if (!m_active) begin
            if (new_cause() != 3'd0) begin
                m_active    = 1;
                m_entry_due = 1;
                m_epc       = cur_pc;
                m_cause     = irq_cause;
                if (m_count < CNT_MX) m_count++;
            end
        end else if (m_entry_due) begin
            m_pend      = merged;
            m_entry_due = 0;
        end else if (m_exit_due) begin
            m_exit_due = 0;
            if (merged != 3'd0) begin
                m_cause = merged;
                m_pend  = 3'd0;
                if (m_count < CNT_MX) m_count++;
            end else begin
                m_active = 0;
            end
        end else begin
            m_pend = merged;
            if (eret) m_exit_due = 1;
        end
    endtask

    task automatic step(input logic r, input logic rq, input logic [2:0] c,
                        input logic [31:0] pc, input logic e);
        rst = r; irq_req = rq; irq_cause = c; cur_pc = pc; eret = e;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1; irq_req = 1'b0; irq_cause = 3'd0; cur_pc = 32'd0; eret = 1'b0;
        m_active = 0; m_entry_due = 0; m_exit_due = 0;
        m_epc = 32'd0; m_cause = 3'd0; m_pend = 3'd0; m_count = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then cause-0 requests must be ignored.
        step(1, 0, 3'd0, 32'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 3'd0, 32'h40, 0);
        chk("idle_after_cause0", {31'd0, in_service}, 32'd0);

        // Basic entry and return.
        step(0, 1, 3'b001, 32'h100, 0);
        step(0, 0, 3'd0, 32'h104, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 32'h50, 0);
        step(0, 0, 3'd0, 32'h54, 1);
        step(0, 0, 3'd0, 32'h58, 0);
        step(0, 0, 3'd0, 32'h100, 0);

        // Tail-chain from a mid-service request.
        step(0, 1, 3'b001, 32'h200, 0);
        step(0, 0, 3'd0, 32'h204, 0);
        step(0, 1, 3'b100, 32'h50, 0);
        step(0, 0, 3'd0, 32'h54, 0);
        step(0, 0, 3'd0, 32'h58, 1);
        step(0, 0, 3'd0, 32'h5c, 0);
        chk("chain_cause", {29'd0, cause}, 32'd4);
        chk("chain_epc", epc, 32'h200);
        step(0, 0, 3'd0, 32'h60, 1);
        step(0, 0, 3'd0, 32'h64, 0);
        step(0, 0, 3'd0, 32'h200, 0);

        // Request coincident with eret tail-chains.
        step(0, 1, 3'b001, 32'h300, 0);
        step(0, 0, 3'd0, 32'h304, 0);
        step(0, 0, 3'd0, 32'h50, 0);
        step(0, 1, 3'b010, 32'h54, 1);
        step(0, 0, 3'd0, 32'h58, 0);
        step(0, 0, 3'd0, 32'h5c, 1);
        step(0, 0, 3'd0, 32'h60, 0);
        step(0, 0, 3'd0, 32'h300, 0);

        // Reset in the middle of service, then a stray eret.
        step(0, 1, 3'b100, 32'h400, 0);
        step(0, 0, 3'd0, 32'h404, 0);
        step(0, 1, 3'b010, 32'h50, 0);
        step(1, 0, 3'd0, 32'h54, 0);
        step(0, 0, 3'd0, 32'h58, 1);
        step(0, 0, 3'd0, 32'h5c, 0);

        // Back-to-back interrupts saturate the counter.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 3'b001, 32'h500 + 32'(i * 4), 0);
            step(0, 0, 3'd0, 32'h600, 0);
            step(0, 0, 3'd0, 32'h604, 1);
            step(0, 0, 3'd0, 32'h608, 0);
        end
        chk("svc_saturated", 32'(svc_count), 32'd3);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 30),
                 3'($urandom_range(0, 7)),
                 {$urandom, 2'b00} & 32'hffff_fffc,
                 ($urandom_range(0, 99) < 20));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_responder.md
Name: interrupt_responder

Overview:
Processor-side responder for the interrupt request line. It accepts a request and its 3-bit cause code ({instr_break, single_step, overflow}), saves the interrupted PC (EPC) and cause, and redirects fetch to the service routine. On the handler's return it restores the PC, and it tail-chains any requests that arrived during service. It sits between the interrupt controller and the PC/fetch mux, so the controller needs no knowledge of PC state.

Parameters:
SERVICE_PC, 32'd76, handler entry address driven on redirect at entry
CNT_W, 8, width of saturating serviced-interrupt counter

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
irq_req  in  1  interrupt request level from the controller
irq_cause  in  3  {instr_break, single_step, overflow}, valid with irq_req
cur_pc  in  32  PC of the instruction to resume at, valid every cycle
eret  in  1  handler return retired (JR out of handler), 1-cycle pulse
irq_ack  out  1  1-cycle pulse when a request is taken into service
pc_redirect  out  1  1-cycle pulse: fetch must load redirect_pc
redirect_pc  out  32  target address, meaningful only while pc_redirect=1
flush  out  1  1-cycle pulse coincident with every pc_redirect
in_service  out  1  high from entry redirect until exit redirect inclusive
epc  out  32  saved return PC
cause  out  3  cause code of the interrupt currently in service
svc_count  out  CNT_W  number of interrupts entered, saturates at all-ones

Behaviour:
- Reset (rst=1 at an edge), from any state, including mid-service:
  - state=IDLE.
  - epc=0, cause=0, pending=0, svc_count=0.
  - All pulses 0, in_service=0, redirect_pc=0.
- A request is valid only when irq_req=1 and irq_cause!=0. irq_req with cause 0 is ignored in all states.
- FSM states: IDLE, ENTER, SERVICE, EXIT.
- IDLE:
  - On a valid request at edge N: epc<=cur_pc, cause<=irq_cause, go to ENTER.
  - eret in IDLE is ignored.
- ENTER (one cycle, N+1):
  - irq_ack=1, pc_redirect=1, flush=1, redirect_pc=SERVICE_PC, in_service=1.
  - svc_count increments, saturating.
  - Next state is SERVICE unconditionally.
  - A valid request in this cycle ORs its cause into pending.
- SERVICE:
  - in_service=1; no redirect.
  - A valid request ORs its cause into pending (sticky); epc and cause do not change.
  - eret goes to EXIT.
  - If eret and a valid request occur in the same cycle, the request is ORed into pending and the FSM goes to EXIT.
- EXIT (one cycle):
  - pc_redirect=1, flush=1, in_service=1.
  - If pending==0, or the next pending value is 0: redirect_pc=epc, next state IDLE, in_service drops the following cycle.
  - If pending!=0 (tail-chain): redirect_pc=SERVICE_PC, irq_ack=1, cause<=pending, pending<=0, svc_count increments, epc unchanged, next state SERVICE.
  - A valid request arriving during EXIT is included: the pending value is evaluated as pending|new cause.
- Nesting is never performed; epc is written only from IDLE.
- Latency: request sampled at edge N gives redirect at cycle N+1. eret sampled at edge M gives return redirect at cycle M+1.
- redirect_pc outputs 0 whenever pc_redirect=0.

Test Plan:
- Reset then idle: all outputs 0. irq_req=1 with cause=0 for 5 cycles -> no irq_ack, state stays IDLE.
- cur_pc=0x100, irq_req=1, cause=3'b001 -> next cycle irq_ack=pc_redirect=flush=1, redirect_pc=76, epc=0x100, cause=001, svc_count=1. eret 4 cycles later -> next cycle pc_redirect=1, redirect_pc=0x100, then in_service=0.
- Tail-chain: in service with cause 001, then irq_req with cause 100 mid-service, then eret -> exit cycle redirect_pc=76, irq_ack=1, cause=100, epc unchanged. A second eret -> redirect_pc=original epc.
- Same-cycle eret and request (cause 010) in SERVICE -> EXIT tail-chains to 76 with cause=010.
- rst asserted during SERVICE -> next cycle state IDLE, epc=0, pending=0. A following eret produces no redirect.
- Set CNT_W=2 and run 5 back-to-back interrupts -> svc_count saturates at 3.
